// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the buffer write port among NUM_REQ producers in bounded bursts.
// Grant one cycle after request, then 1 beat/cycle; fifo_full stalls beats while the grant is held.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk_1,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [2:0]                owner_id,
  output logic                      busy,
  output logic [15:0]               beat_count
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]        state;
  logic [2:0]        rr_ptr;
  logic [7:0]        burst_cnt;
  logic              own_req;
  logic [DATA_W-1:0] own_data;
  logic              accept;
  logic              grant_vld;
  logic [2:0]        grant_idx;
  logic [3:0]        cand;
  logic [2:0]        next_ptr;
  logic              last_beat;

  // Rotating priority scan starting at rr_ptr; indices wrap at NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 3'd0;
    cand      = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_vld && cand == 4'(j) && req[j]) begin
          grant_vld = 1'b1;
          grant_idx = cand[2:0];
        end
      end
    end
  end

  always_comb begin
    own_req  = 1'b0;
    own_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner_id == 3'(j)) begin
        own_req  = req[j];
        own_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  assign busy      = (state == ST_BURST);
  assign accept    = busy && own_req && !fifo_full && !rst;
  assign last_beat = (burst_cnt == 8'(MAX_BURST - 1));
  assign next_ptr  = (owner_id == 3'(NUM_REQ - 1)) ? 3'd0 : owner_id + 3'd1;

  always_comb begin
    ack = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (accept && owner_id == 3'(j)) ack[j] = 1'b1;
    end
  end

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = busy ? own_data : '0;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state      <= ST_ARB;
      owner_id   <= 3'd0;
      rr_ptr     <= 3'd0;
      burst_cnt  <= 8'd0;
      beat_count <= 16'd0;
    end else begin
      case (state)
        ST_ARB: begin
          if (grant_vld) begin
            owner_id  <= grant_idx;
            burst_cnt <= 8'd0;
            state     <= ST_BURST;
          end
        end
        default: begin
          if (!own_req) begin
            // Owner gave up the grant (zero-beat or early end).
            state  <= ST_ARB;
            rr_ptr <= next_ptr;
          end else if (accept) begin
            burst_cnt  <= burst_cnt + 8'd1;
            beat_count <= beat_count + 16'd1;
            if (last_beat) begin
              state  <= ST_ARB;
              rr_ptr <= next_ptr;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a rotation/burst reference model; a second instance checks counter wrap.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic          clk_1 = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*16-1:0] req_data;
  logic          fifo_full;
  logic [N-1:0]  ack;
  logic          fifo_wr_en;
  logic [15:0]   fifo_wr_data;
  logic [2:0]    owner_id;
  logic          busy;
  logic [15:0]   beat_count;

  logic          w_rst;
  logic [1:0]    w_req;
  logic [31:0]   w_req_data;
  logic          w_full;
  logic [1:0]    w_ack;
  logic          w_wr_en;
  logic [15:0]   w_wr_data;
  logic [2:0]    w_owner_id;
  logic          w_busy;
  logic [15:0]   w_beat_count;

  always #5 clk_1 = ~clk_1;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(16), .MAX_BURST(MB)) dut (
    .clk_1(clk_1), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
    .ack(ack), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .owner_id(owner_id), .busy(busy), .beat_count(beat_count)
  );

  fifo_wr_arbiter #(.NUM_REQ(2), .DATA_W(16), .MAX_BURST(255)) dut_wrap (
    .clk_1(clk_1), .rst(w_rst), .req(w_req), .req_data(w_req_data), .fifo_full(w_full),
    .ack(w_ack), .fifo_wr_en(w_wr_en), .fifo_wr_data(w_wr_data),
    .owner_id(w_owner_id), .busy(w_busy), .beat_count(w_beat_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Producers: rem beats still to send, seq numbers the current beat.
  int         rem [N];
  logic [11:0] seq [N];
  logic       t_rst;
  logic       t_full;

  // Reference model: grant holder, rotation start, beats in this grant, total beats.
  bit m_busy;
  int m_owner, m_ptr, m_cnt, m_beats;

  function automatic logic [15:0] beat_of(input int i);
    return {4'(i), seq[i]};
  endfunction

  task automatic step();
    logic acc;
    @(negedge clk_1);
    rst       = t_rst;
    fifo_full = t_full;
    for (int i = 0; i < N; i++) begin
      req[i]               = (rem[i] > 0);
      req_data[i*16 +: 16] = beat_of(i);
    end
    #2;
    acc = m_busy && req[m_owner] && !t_full && !t_rst;
    check_val("ack", 32'(ack), acc ? (32'd1 << m_owner) : 32'd0);
    check_val("wr_en", 32'(fifo_wr_en), 32'(acc));
    check_val("wr_data", 32'(fifo_wr_data), m_busy ? 32'(beat_of(m_owner)) : 32'd0);
    check_val("busy", 32'(busy), 32'(m_busy));
    check_val("beat_count", 32'(beat_count), 32'(m_beats % 65536));
    if (m_busy) check_val("owner", 32'(owner_id), 32'(m_owner));

    if (t_rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_beats = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (!m_busy && req[(m_ptr + k) % N]) begin
          m_busy  = 1;
          m_owner = (m_ptr + k) % N;
          m_cnt   = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (acc) begin
      seq[m_owner]++;
      rem[m_owner]--;
      m_cnt++;
      m_beats = (m_beats + 1) % 65536;
      if (m_cnt == MB) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic main_test();
    int grants[$];
    bit prev_busy;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 12'h0; end
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_beats = 0;
    rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;
    t_rst = 1'b1; t_full = 1'b0;
    repeat (2) @(posedge clk_1);
    step();
    check_val("rst_owner", 32'(owner_id), 32'd0);
    t_rst = 1'b0;

    // Single requester: 6 beats as 4 + dead cycle + 2, then req drops.
    rem[2] = 6;
    repeat (10) step();
    check_val("single_beats", 32'(beat_count), 32'd6);
    for (int i = 0; i < N; i++) rem[i] = 2;
    repeat (2) step();
    check_val("rr_next", 32'(owner_id), 32'd3);
    repeat (14) step();

    // Fairness with all requesters saturated.
    t_rst = 1'b1; step(); t_rst = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 1000;
    prev_busy = 1'b0;
    repeat (25) begin
      step();
      if (busy && !prev_busy) grants.push_back(int'(owner_id));
      prev_busy = busy;
    end
    for (int g = 0; g < 5; g++)
      check_val("rr_order", (g < grants.size()) ? 32'(grants[g]) : 32'hDEAD, 32'(exp_order[g]));

    // Reset mid-burst, then req[0] must win again.
    repeat (2) step();
    t_rst = 1'b1; step(); t_rst = 1'b0;
    repeat (3) step();
    check_val("post_rst_owner", 32'(owner_id), 32'd0);
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (3) step();

    // Full stall after 2 beats, then the remaining 2 beats of the burst.
    rem[1] = 6;
    repeat (3) step();
    t_full = 1'b1; repeat (3) step();
    t_full = 1'b0; repeat (4) step();
    for (int i = 0; i < N; i++) rem[i] = 0;
    repeat (4) step();

    repeat (3000) begin
      t_rst  = ($urandom_range(0, 99) == 0);
      t_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 9);
        else if (rem[i] > 0 && $urandom_range(0, 49) == 0) rem[i] = 0;
      end
      step();
    end
  endtask

  task automatic wrap_test();
    int beats = 0;
    int cycles = 0;
    w_rst = 1'b1; w_req = 2'b00; w_req_data = 32'h0000_1234; w_full = 1'b0;
    repeat (2) @(posedge clk_1);
    @(negedge clk_1);
    w_rst = 1'b0; w_req = 2'b01;
    while (beats < 65537 && cycles < 70000) begin
      @(negedge clk_1);
      #1;
      cycles++;
      if (w_wr_en) beats++;
    end
    check_val("wrap_beats", 32'(beats), 32'd65537);
    check_val("wrap_zero", 32'(w_beat_count), 32'd0);
    @(negedge clk_1);
    #1;
    check_val("wrap_one", 32'(w_beat_count), 32'd1);
    w_req = 2'b00;
  endtask

  initial begin
    fork
      main_test();
      wrap_test();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter in the clk_1 domain that shares the single write side of the dual-clock 8x16 buffer among up to eight producers. It grants one requester at a time for a bounded burst, stalls beats while the buffer reports full, and drives the buffer's data_1/data_1_en inputs directly. It also keeps a free-running count of accepted beats for debug.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, beat width (matches buffer data_1)
- MAX_BURST, 4, max accepted beats per grant (1..255)

- clk_1  in  1  write-domain clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request; held high with stable data until ack
- req_data  in  NUM_REQ*DATA_W  flattened data, requester i at bits [i*DATA_W +: DATA_W]
- fifo_full  in  1  buffer_full from the buffer
- ack  out  NUM_REQ  one-hot; beat of requester i accepted this cycle
- fifo_wr_en  out  1  to buffer data_1_en
- fifo_wr_data  out  DATA_W  to buffer data_1
- owner_id  out  3  index of current grant holder (valid when busy)
- busy  out  1  high in BURST state
- beat_count  out  16  total accepted beats, wraps 0xFFFF->0x0000

## Operation
- States: ARB, BURST. Registered: state, owner_id, rr_ptr (3 bits), burst_cnt (8 bits), beat_count.
- ARB: if any req bit high, select first high index scanning rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1; load owner_id, clear burst_cnt, go BURST. fifo_full is ignored during selection. No req -> stay in ARB.
- BURST, beat condition: accept = req[owner_id] && !fifo_full && !rst.
- ack[owner_id] = fifo_wr_en = accept (combinational from registered state plus inputs); fifo_wr_data = req_data slice of owner_id whenever busy, else 0.
- On accept: burst_cnt+1, beat_count+1 (mod 2^16).
- Release, back to ARB next cycle with rr_ptr = (owner_id+1) mod NUM_REQ, when either:
  - the accepted beat makes burst_cnt reach MAX_BURST; or
  - req[owner_id] is low while in BURST (zero-beat or early end).
- fifo_full high in BURST: no ack, no write, burst_cnt held, grant kept indefinitely. The block has no timeout.
- Non-owner req bits are ignored in BURST; those requesters wait, with no ack.
- Requester contract: after an ack, it presents the next beat or drops req before the next edge.

## Timing
- Reset values: state=ARB, owner_id=0, rr_ptr=0, burst_cnt=0, beat_count=0, busy=0, ack=0, fifo_wr_en=0, fifo_wr_data=0.
- While rst is high, ack and fifo_wr_en are forced to 0 combinationally, even if state is still BURST.
- Reset mid-burst abandons the burst; no beat is written in the rst cycle.
- Grant latency: req rises in cycle t (idle ARB) -> BURST from cycle t+1 -> first ack/fifo_wr_en in t+1 if !fifo_full.
- Throughput: 1 beat/cycle within a burst. Exactly one ARB (dead) cycle between consecutive bursts.
- fifo_full is sampled combinationally the same cycle. The buffer captures data_1 on the clk_1 edge ending the ack cycle.
- MAX_BURST=1: each grant carries one beat, so every beat costs 2 cycles.
- rr_ptr wraps at NUM_REQ, not at 8.

## Test plan
- Single requester: NUM_REQ=4, MAX_BURST=4, req[2] high with data 0xA000..0xA005 advanced on ack -> writes A000-A003 in cycles 1-4, one ARB cycle, A004-A005, then req drops -> beat_count=6, rr_ptr=3.
- Fairness: req=4'b1111 held constant -> owner order 0,1,2,3,0, each burst exactly 4 acks, one idle cycle between bursts.
- Full stall: mid-burst (2 beats done), fifo_full high 3 cycles -> no ack/fifo_wr_en, owner unchanged. After full drops, exactly 2 more beats, then release.
- Early release: owner drops req after 1 beat -> ARB next cycle, next requester granted; burst_cnt not carried over.
- Reset mid-burst: rst high for 1 cycle during a BURST beat -> fifo_wr_en=0 that cycle; next cycle all outputs at reset values, rr_ptr=0; req[0] wins next arbitration.
- Counter wrap: preload traffic for 65537 beats -> beat_count reads 0x0001.
